// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: op-select encoding, FSM states and op classification for alu_seq (macro ALU_SEQ_DIV_EN enables DIV)
package alu_seq_pkg;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_DIV = 3'b110;
    localparam logic [2:0] OP_RSV = 3'b111;

    typedef enum logic {ST_IDLE, ST_CALC} state_t;

    function automatic logic is_iter_op(input logic [2:0] f);
`ifdef ALU_SEQ_DIV_EN
        return f == OP_MUL || f == OP_DIV;
`else
        return f == OP_MUL;
`endif
    endfunction
endpackage

// File: rtl/alu_seq_iter.sv
// alu_seq_iter: one-step-per-cycle shift-add multiplier, plus restoring divider when ALU_SEQ_DIV_EN is defined
module alu_seq_iter #(
    parameter int WIDTH = 4
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               go,
    input  logic               mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] result
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] prod, prod_nx;
    logic [WIDTH-1:0]   m;
    logic [CW-1:0]      cnt;
    logic               run, start;
    logic [WIDTH:0]     sum;
`ifdef ALU_SEQ_DIV_EN
    logic               div_r, ge;
    logic [WIDTH:0]     shifted;
    logic [WIDTH-1:0]   rem;
    assign start = go;
`else
    assign start = go && !mode;
`endif

    assign done = run && cnt == LAST;

    // One partial product (or one quotient bit) per cycle; result is the value the final step produces
    always_comb begin
        sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, prod[0] ? m : {WIDTH{1'b0}}};
        prod_nx = {sum, prod[WIDTH-1:1]};
        result = prod_nx;
`ifdef ALU_SEQ_DIV_EN
        shifted = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
        ge = shifted >= {1'b0, m};
        rem = ge ? shifted[WIDTH-1:0] - m : shifted[WIDTH-1:0];
        prod_nx = div_r ? {rem, prod[WIDTH-2:0], ge} : prod_nx;
        result = div_r && m == '0 ? '1 : prod_nx;
`endif
    end

    // Load operands on go, then step until the last iteration completes
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            run  <= 1'b0;
            cnt  <= '0;
            prod <= '0;
            m    <= '0;
`ifdef ALU_SEQ_DIV_EN
            div_r <= 1'b0;
`endif
        end else if (start) begin
            run  <= 1'b1;
            cnt  <= '0;
`ifdef ALU_SEQ_DIV_EN
            div_r <= mode;
            m    <= mode ? b : a;
            prod <= {{WIDTH{1'b0}}, mode ? a : b};
`else
            m    <= a;
            prod <= {{WIDTH{1'b0}}, b};
`endif
        end else if (run) begin
            prod <= prod_nx;
            cnt  <= cnt + 1'b1;
            run  <= !done;
        end
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with Start/Busy/Done handshake and iterative MUL (DIV when ALU_SEQ_DIV_EN is defined)
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [2:0]         Fsel,
    output logic               Busy,
    output logic               Done,
    output logic               Err,
    output logic [2*WIDTH-1:0] O
);
    state_t             state, state_nx;
    logic               accept, iter_go, iter_mode, iter_done, iter_err, sc_err;
    logic [2*WIDTH-1:0] sc_o, iter_result;
    logic [WIDTH:0]     sum, diff;

    assign Busy = state == ST_CALC;
    assign iter_mode = Fsel == OP_DIV;

    alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
        .Clk(Clk),
        .Rst(Rst),
        .go(iter_go),
        .mode(iter_mode),
        .a(A),
        .b(B),
        .done(iter_done),
        .result(iter_result)
    );

    // Requests are taken only when idle; iterative ops park the FSM in CALC until the datapath finishes
    always_comb begin
        accept = Start && state == ST_IDLE;
        iter_go = accept && is_iter_op(Fsel);
        state_nx = iter_go ? ST_CALC : (state == ST_CALC && iter_done) ? ST_IDLE : state;
    end

    // State register
    always_ff @(posedge Clk) begin
        state <= !Rst ? ST_IDLE : state_nx;
    end

    // Single-cycle results; carry/borrow lands in bit WIDTH, anything unlisted is illegal
    always_comb begin
        sum = {1'b0, A} + {1'b0, B};
        diff = {1'b0, A} - {1'b0, B};
        sc_err = !(Fsel inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR});
        sc_o = Fsel == OP_ADD ? {{(WIDTH-1){1'b0}}, sum}
             : Fsel == OP_SUB ? {{(WIDTH-1){1'b0}}, diff}
             : Fsel == OP_AND ? {{WIDTH{1'b0}}, A & B}
             : Fsel == OP_OR  ? {{WIDTH{1'b0}}, A | B}
             : Fsel == OP_XOR ? {{WIDTH{1'b0}}, A ^ B}
             : '0;
    end

`ifdef ALU_SEQ_DIV_EN
    logic zero_r;
    // Remember a zero divisor so the divide reports Err when it finishes
    always_ff @(posedge Clk) begin
        zero_r <= !Rst ? 1'b0 : iter_go ? (iter_mode && B == '0) : zero_r;
    end
    assign iter_err = zero_r;
`else
    assign iter_err = 1'b0;
`endif

    // Output registers: O/Err held between Done pulses, Done high only on a completing edge
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            O    <= '0;
            Err  <= 1'b0;
            Done <= 1'b0;
        end else if (accept && !iter_go) begin
            O    <= sc_o;
            Err  <= sc_err;
            Done <= 1'b1;
        end else if (state == ST_CALC && iter_done) begin
            O    <= iter_result;
            Err  <= iter_err;
            Done <= 1'b1;
        end else begin
            Done <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq at WIDTH=4 and WIDTH=8
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic        Clk = 1'b0, Rst = 1'b0, Start = 1'b0;
    logic [3:0]  A = '0, B = '0;
    logic [2:0]  Fsel = '0;
    logic        Busy, Done, Err;
    logic [7:0]  O;
    logic        Start8 = 1'b0;
    logic [7:0]  A8 = '0, B8 = '0;
    logic [2:0]  Fsel8 = '0;
    logic        Busy8, Done8, Err8;
    logic [15:0] O8;
    int total = 0, bad = 0;

    alu_seq #(.WIDTH(4)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .A(A), .B(B), .Fsel(Fsel),
        .Busy(Busy), .Done(Done), .Err(Err), .O(O)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .Clk(Clk), .Rst(Rst), .Start(Start8), .A(A8), .B(B8), .Fsel(Fsel8),
        .Busy(Busy8), .Done(Done8), .Err(Err8), .O(O8)
    );

    always #5 Clk = ~Clk;

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset;
        Rst = 1'b0; Start = 1'b1; Fsel = OP_MUL; A = 4'hF; B = 4'hF;
        Start8 = 1'b1; Fsel8 = OP_ADD; A8 = 8'd1; B8 = 8'd1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if ({O, Err, Done, Busy} !== 11'h0) begin
                bad++;
                $display("FAIL reset4[%0d] O=%h Err=%b Done=%b Busy=%b want all zero", i, O, Err, Done, Busy);
            end
            total++;
            if ({O8, Err8, Done8, Busy8} !== 19'h0) begin
                bad++;
                $display("FAIL reset8[%0d] O=%h Err=%b Done=%b Busy=%b want all zero", i, O8, Err8, Done8, Busy8);
            end
        end
        Start = 1'b0; Start8 = 1'b0; Rst = 1'b1;
        tick();
    endtask

    task automatic test_single;
        logic [2:0] fv [8];
        logic [3:0] av [8];
        logic [3:0] bv [8];
        logic [7:0] ev [8];
        fv = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SUB, OP_AND, OP_ADD};
        av = '{4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd2, 4'hC, 4'hF};
        bv = '{4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd4, 4'hA, 4'hF};
        ev = '{8'h06, 8'h02, 8'h00, 8'h06, 8'h06, 8'h1E, 8'h08, 8'h1E};
        for (int i = 0; i < 8; i++) begin
            Fsel = fv[i]; A = av[i]; B = bv[i]; Start = 1'b1;
            tick();
            total++;
            if ({O, Err, Done} !== {ev[i], 1'b0, 1'b1}) begin
                bad++;
                $display("FAIL single[%0d] O=%h Err=%b Done=%b want O=%h Err=0 Done=1", i, O, Err, Done, ev[i]);
            end
            Start = 1'b0;
            tick();
            total++;
            if ({O, Done} !== {ev[i], 1'b0}) begin
                bad++;
                $display("FAIL single_hold[%0d] O=%h Done=%b want O=%h Done=0", i, O, Done, ev[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        Start = 1'b1; Fsel = OP_ADD; A = 4'd1; B = 4'd2;
        tick();
        total++;
        if ({O, Done} !== {8'h03, 1'b1}) begin
            bad++;
            $display("FAIL b2b_add O=%h Done=%b want O=03 Done=1", O, Done);
        end
        Fsel = OP_XOR; A = 4'd5; B = 4'd3;
        tick();
        total++;
        if ({O, Done} !== {8'h06, 1'b1}) begin
            bad++;
            $display("FAIL b2b_xor O=%h Done=%b want O=06 Done=1", O, Done);
        end
        Fsel = OP_OR; A = 4'd8; B = 4'd1;
        tick();
        total++;
        if ({O, Done} !== {8'h09, 1'b1}) begin
            bad++;
            $display("FAIL b2b_or O=%h Done=%b want O=09 Done=1", O, Done);
        end
        Start = 1'b0;
        tick();
        total++;
        if (Done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_end Done=%b want 0", Done);
        end
    endtask

    task automatic test_mul;
        Start = 1'b1; Fsel = OP_MUL; A = 4'd15; B = 4'd15;
        tick();
        total++;
        if ({Busy, Done} !== 2'b10) begin
            bad++;
            $display("FAIL mul_accept Busy=%b Done=%b want Busy=1 Done=0", Busy, Done);
        end
        Fsel = OP_ADD; A = 4'd1; B = 4'd1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({Busy, Done} !== 2'b10) begin
                bad++;
                $display("FAIL mul_busy[%0d] Busy=%b Done=%b want Busy=1 Done=0", i, Busy, Done);
            end
        end
        tick();
        total++;
        if ({O, Err, Done, Busy} !== {8'hE1, 1'b0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL mul_done O=%h Err=%b Done=%b Busy=%b want O=e1 Err=0 Done=1 Busy=0", O, Err, Done, Busy);
        end
        Start = 1'b0;
        tick();
        total++;
        if ({O, Done, Busy} !== {8'hE1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL mul_ignored O=%h Done=%b Busy=%b want O=e1 Done=0 Busy=0", O, Done, Busy);
        end
        Start = 1'b1; Fsel = OP_RSV; A = 4'd3; B = 4'd3;
        tick();
        total++;
        if ({O, Err, Done} !== {8'h00, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL illegal O=%h Err=%b Done=%b want O=00 Err=1 Done=1", O, Err, Done);
        end
        Start = 1'b0;
        tick();
        total++;
        if ({Err, Done} !== 2'b10) begin
            bad++;
            $display("FAIL err_hold Err=%b Done=%b want Err=1 Done=0", Err, Done);
        end
        Start = 1'b1; Fsel = OP_ADD; A = 4'd1; B = 4'd1;
        tick();
        total++;
        if ({O, Err, Done} !== {8'h02, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL err_clear O=%h Err=%b Done=%b want O=02 Err=0 Done=1", O, Err, Done);
        end
        Start = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid;
        Start = 1'b1; Fsel = OP_MUL; A = 4'd3; B = 4'd5;
        tick();
        Start = 1'b0;
        tick();
        Rst = 1'b0;
        tick();
        total++;
        if ({O, Err, Done, Busy} !== 11'h0) begin
            bad++;
            $display("FAIL reset_mid O=%h Err=%b Done=%b Busy=%b want all zero", O, Err, Done, Busy);
        end
        Rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if ({O, Done, Busy} !== 10'h0) begin
                bad++;
                $display("FAIL reset_mid_quiet[%0d] O=%h Done=%b Busy=%b want all zero", i, O, Done, Busy);
            end
        end
        Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        tick();
        total++;
        if ({O, Err, Done, Busy} !== {8'h0F, 1'b0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL mul_3x5 O=%h Err=%b Done=%b Busy=%b want O=0f Err=0 Done=1 Busy=0", O, Err, Done, Busy);
        end
        tick();
    endtask

    task automatic test_div;
`ifdef ALU_SEQ_DIV_EN
        Start = 1'b1; Fsel = OP_DIV; A = 4'd13; B = 4'd4;
        tick();
        Start = 1'b0;
        total++;
        if ({Busy, Done} !== 2'b10) begin
            bad++;
            $display("FAIL div_accept Busy=%b Done=%b want Busy=1 Done=0", Busy, Done);
        end
        for (int i = 0; i < 3; i++) tick();
        tick();
        total++;
        if ({O, Err, Done, Busy} !== {8'h13, 1'b0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL div_13_4 O=%h Err=%b Done=%b Busy=%b want O=13 Err=0 Done=1 Busy=0", O, Err, Done, Busy);
        end
        Start = 1'b1; A = 4'd7; B = 4'd0;
        tick();
        Start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        tick();
        total++;
        if ({O, Err, Done, Busy} !== {8'hFF, 1'b1, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL div_by_zero O=%h Err=%b Done=%b Busy=%b want O=ff Err=1 Done=1 Busy=0", O, Err, Done, Busy);
        end
`else
        Start = 1'b1; Fsel = OP_DIV; A = 4'd13; B = 4'd4;
        tick();
        Start = 1'b0;
        total++;
        if ({O, Err, Done, Busy} !== {8'h00, 1'b1, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL div_illegal O=%h Err=%b Done=%b Busy=%b want O=00 Err=1 Done=1 Busy=0", O, Err, Done, Busy);
        end
`endif
        tick();
    endtask

    task automatic test_wide;
        Start8 = 1'b1; Fsel8 = OP_MUL; A8 = 8'd255; B8 = 8'd255;
        tick();
        Start8 = 1'b0;
        total++;
        if ({Busy8, Done8} !== 2'b10) begin
            bad++;
            $display("FAIL mul8_accept Busy=%b Done=%b want Busy=1 Done=0", Busy8, Done8);
        end
        for (int i = 0; i < 7; i++) begin
            tick();
            total++;
            if ({Busy8, Done8} !== 2'b10) begin
                bad++;
                $display("FAIL mul8_busy[%0d] Busy=%b Done=%b want Busy=1 Done=0", i, Busy8, Done8);
            end
        end
        tick();
        total++;
        if ({O8, Err8, Done8, Busy8} !== {16'hFE01, 1'b0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL mul8_done O=%h Err=%b Done=%b Busy=%b want O=fe01 Err=0 Done=1 Busy=0", O8, Err8, Done8, Busy8);
        end
        Start8 = 1'b1; Fsel8 = OP_ADD; A8 = 8'd200; B8 = 8'd100;
        tick();
        Start8 = 1'b0;
        total++;
        if ({O8, Err8, Done8} !== {16'h012C, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL add8 O=%h Err=%b Done=%b want O=012c Err=0 Done=1", O8, Err8, Done8);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_mul();
        test_reset_mid();
        test_div();
        test_wide();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
